// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and timing constants for the UART RX path.
//   rx_state_t : receive sequencer states
//   OSR        : oversampling ratio (ticks per bit)
//   START_MID  : tick count at which the start bit is re-checked
//   BIT_END    : tick count at which data/parity/stop bits are sampled
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int       OSR       = 16;
  localparam logic [3:0] START_MID = 4'd7;
  localparam logic [3:0] BIT_END   = 4'd15;

endpackage

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer. Validates the start bit at its
// middle, samples data/parity/stop bits one bit-period later each, and
// presents the character on a valid/ready interface with error flags.
//   clk, rst_n    : clock, async active-low reset
//   tick_16x      : one-clk strobe at 16x baud
//   rx_filtered   : filtered serial line (idle high)
//   falling_edge  : one-clk strobe on filtered high-to-low transition
//   rx_data       : received character, LSB first on the line
//   rx_valid/ready: output handshake
//   frame_err     : stop bit(s) sampled low (qualified by rx_valid)
//   parity_err    : parity mismatch (qualified by rx_valid)
//   overrun_err   : one-clk pulse when a completed frame is dropped
//   busy          : sequencer not idle
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_16x,
  input  logic                 rx_filtered,
  input  logic                 falling_edge,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  rx_state_t state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q;
  logic ferr_q, perr_q;

  // per-cycle datapath strobes from the FSM
  logic err_clr, shift_en, par_smp, stop_smp, done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    err_clr  = 1'b0;
    shift_en = 1'b0;
    par_smp  = 1'b0;
    stop_smp = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: if (falling_edge) begin
        state_d = START;
        tick_d  = '0;
      end
      START: if (tick_16x) begin
        if (tick_q == START_MID) begin
          // line back high at mid-start is a glitch: silently abandon
          tick_d  = '0;
          bit_d   = '0;
          state_d = rx_filtered ? IDLE : DATA;
          err_clr = ~rx_filtered;
        end else begin
          tick_d = tick_q + 4'd1;
        end
      end
      DATA: if (tick_16x) begin
        tick_d = tick_q + 4'd1;
        if (tick_q == BIT_END) begin
          shift_en = 1'b1;
          bit_d    = bit_q + 3'd1;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: if (tick_16x) begin
        tick_d = tick_q + 4'd1;
        if (tick_q == BIT_END) begin
          par_smp = 1'b1;
          bit_d   = '0;
          state_d = STOP;
        end
      end
      STOP: if (tick_16x) begin
        tick_d = tick_q + 4'd1;
        if (tick_q == BIT_END) begin
          stop_smp = 1'b1;
          // bit_cnt is reused to count stop bits
          if (bit_q == LAST_STOP) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q     <= '0;
      ferr_q      <= 1'b0;
      perr_q      <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      busy        <= (state_d != IDLE);
      overrun_err <= 1'b0;
      if (err_clr) begin
        ferr_q <= 1'b0;
        perr_q <= 1'b0;
      end
      if (shift_en) shreg_q <= {rx_filtered, shreg_q[DATA_BITS-1:1]};
      if (par_smp)  perr_q  <= (^{shreg_q, rx_filtered}) ^ (PARITY_ODD != 0);
      if (stop_smp && !rx_filtered) ferr_q <= 1'b1;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg_q;
          // last stop sample is folded in directly; ferr_q only holds earlier ones
          frame_err  <= ferr_q | ~rx_filtered;
          parity_err <= (PARITY_EN != 0) ? perr_q : 1'b0;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: three instances (8N1, 8E1, 8N2), each
// with its own line, edge strobe and ready, sharing clock/reset/tick.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_16x = 1'b0;
  logic [2:0] line = 3'b111;
  logic [2:0] fe = 3'b000;
  logic [2:0] rdy = 3'b111;
  logic [7:0] dat0, dat1, dat2;
  logic [2:0] vld, ferr, perr, ovr, bsy;

  int nchk = 0, npass = 0, nfail = 0;
  int tdiv = 0;

  always #5 clk = ~clk;

  // tick every 4 clk, changed on the falling edge
  always @(negedge clk) begin
    if (tdiv == 3) begin tdiv = 0; tick_16x = 1'b1; end
    else begin tdiv = tdiv + 1; tick_16x = 1'b0; end
  end

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .tick_16x(tick_16x), .rx_filtered(line[0]),
    .falling_edge(fe[0]), .rx_data(dat0), .rx_valid(vld[0]), .rx_ready(rdy[0]),
    .frame_err(ferr[0]), .parity_err(perr[0]), .overrun_err(ovr[0]), .busy(bsy[0]));

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .tick_16x(tick_16x), .rx_filtered(line[1]),
    .falling_edge(fe[1]), .rx_data(dat1), .rx_valid(vld[1]), .rx_ready(rdy[1]),
    .frame_err(ferr[1]), .parity_err(perr[1]), .overrun_err(ovr[1]), .busy(bsy[1]));

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst_n(rst_n), .tick_16x(tick_16x), .rx_filtered(line[2]),
    .falling_edge(fe[2]), .rx_data(dat2), .rx_valid(vld[2]), .rx_ready(rdy[2]),
    .frame_err(ferr[2]), .parity_err(perr[2]), .overrun_err(ovr[2]), .busy(bsy[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!tick_16x) @(posedge clk);
    end
  endtask

  // Start bit plus nbits of 'bits' (LSB first). Returns 7 ticks into the
  // last bit, i.e. one tick before that bit's sample point.
  task automatic send_frame(input int idx, input logic [11:0] bits, input int nbits);
    @(negedge clk); line[idx] = 1'b0; fe[idx] = 1'b1;
    @(negedge clk); fe[idx] = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); line[idx] = bits[i];
      wait_ticks((i == nbits - 1) ? 7 : 16);
    end
  endtask

  task automatic last_tick();
    wait_ticks(1);
    #1;
  endtask

  task automatic finish_frame(input int idx);
    wait_ticks(8);
    @(negedge clk); line[idx] = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hits;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(dat0), 0);
    chk("rst_valid", 32'(vld), 0);
    chk("rst_busy", 32'(bsy), 0);
    chk("rst_flags", 32'({ferr, perr, ovr}), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // 8N1 0xA5, ready=1, completion exactly 152 ticks after the edge
    send_frame(0, 12'h1A5, 9);
    #1;
    chk("a5_pre_valid", 32'(vld[0]), 0);
    chk("a5_pre_busy", 32'(bsy[0]), 1);
    last_tick();
    chk("a5_valid", 32'(vld[0]), 1);
    chk("a5_data", 32'(dat0), 'hA5);
    chk("a5_ferr", 32'(ferr[0]), 0);
    chk("a5_perr", 32'(perr[0]), 0);
    chk("a5_busy", 32'(bsy[0]), 0);
    @(posedge clk); #1;
    chk("a5_valid_drop", 32'(vld[0]), 0);
    finish_frame(0);

    // glitch: low for 3 ticks, false start at the 8th tick
    @(negedge clk); line[0] = 1'b0; fe[0] = 1'b1;
    @(negedge clk); fe[0] = 1'b0;
    wait_ticks(3);
    @(negedge clk); line[0] = 1'b1;
    wait_ticks(4); #1;
    chk("glitch_busy", 32'(bsy[0]), 1);
    last_tick();
    chk("glitch_idle", 32'(bsy[0]), 0);
    hits = 0;
    repeat (640) begin @(posedge clk); #1; if (vld[0]) hits++; end
    chk("glitch_novalid", 32'(hits), 0);

    // even parity: 0x07 with parity 1 is good, with parity 0 is bad
    send_frame(1, 12'h307, 10);
    last_tick();
    chk("par_ok_valid", 32'(vld[1]), 1);
    chk("par_ok_data", 32'(dat1), 'h07);
    chk("par_ok_perr", 32'(perr[1]), 0);
    finish_frame(1);
    send_frame(1, 12'h207, 10);
    last_tick();
    chk("par_bad_valid", 32'(vld[1]), 1);
    chk("par_bad_data", 32'(dat1), 'h07);
    chk("par_bad_perr", 32'(perr[1]), 1);
    chk("par_bad_ferr", 32'(ferr[1]), 0);
    finish_frame(1);

    // two stop bits, second low
    send_frame(2, 12'h13C, 10);
    #1;
    chk("stop2_pre_valid", 32'(vld[2]), 0);
    last_tick();
    chk("stop2_valid", 32'(vld[2]), 1);
    chk("stop2_data", 32'(dat2), 'h3C);
    chk("stop2_ferr", 32'(ferr[2]), 1);
    finish_frame(2);

    // overrun with rx_ready low
    rdy[0] = 1'b0;
    send_frame(0, 12'h111, 9);
    last_tick();
    chk("ovr_first_valid", 32'(vld[0]), 1);
    chk("ovr_first_data", 32'(dat0), 'h11);
    finish_frame(0);
    send_frame(0, 12'h122, 9);
    last_tick();
    chk("ovr_pulse", 32'(ovr[0]), 1);
    chk("ovr_keep_data", 32'(dat0), 'h11);
    chk("ovr_keep_valid", 32'(vld[0]), 1);
    @(posedge clk); #1;
    chk("ovr_pulse_end", 32'(ovr[0]), 0);
    finish_frame(0);

    // ready asserted in exactly the completion clk: load, no overrun
    send_frame(0, 12'h122, 9);
    do begin @(negedge clk); #1; end while (!tick_16x);
    rdy[0] = 1'b1;
    @(posedge clk); #1;
    chk("rdy_load_valid", 32'(vld[0]), 1);
    chk("rdy_load_data", 32'(dat0), 'h22);
    chk("rdy_load_novr", 32'(ovr[0]), 0);
    @(negedge clk); rdy[0] = 1'b0;
    @(posedge clk); #1;
    chk("rdy_hold_data", 32'(dat0), 'h22);
    chk("rdy_hold_valid", 32'(vld[0]), 1);
    finish_frame(0);

    // reset during bit 4 of 0x55, with 0x22 still pending
    send_frame(0, 12'h015, 5);
    #1;
    chk("mid_busy", 32'(bsy[0]), 1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(vld[0]), 0);
    chk("mid_rst_data", 32'(dat0), 0);
    chk("mid_rst_busy", 32'(bsy[0]), 0);
    chk("mid_rst_flags", 32'({ferr[0], perr[0], ovr[0]}), 0);
    line[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rdy[0] = 1'b1;
    repeat (4) @(posedge clk);
    send_frame(0, 12'h199, 9);
    last_tick();
    chk("post_valid", 32'(vld[0]), 1);
    chk("post_data", 32'(dat0), 'h99);
    chk("post_ferr", 32'(ferr[0]), 0);
    finish_frame(0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side sequencer for the UART RX path. Consumes the synchronized, majority-filtered line and falling-edge strobe from the input filter, plus the 16x oversampling tick. Validates the start bit, samples each data, parity and stop bit at mid-bit, then presents the assembled character on a valid/ready output with error flags. Sits between the input filter and the RX FIFO/bus interface inside the uart_rx top level.

## Interface
Parameters:
- DATA_BITS, 8: character width, legal 5..8
- PARITY_EN, 0: 1 = parity bit follows the data bits
- PARITY_ODD, 0: 1 = odd parity, 0 = even; ignored when PARITY_EN=0
- STOP_BITS, 1: legal 1 or 2

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick_16x  in  1  one-clk strobe at 16x baud
- rx_filtered  in  1  filtered serial line (idle high)
- falling_edge  in  1  one-clk strobe on a filtered high-to-low transition
- rx_data  out  DATA_BITS  received character, LSB = first bit on the line
- rx_valid  out  1  rx_data and error flags are valid
- rx_ready  in  1  consumer accepts when rx_valid && rx_ready
- frame_err  out  1  stop bit(s) sampled low; qualified by rx_valid
- parity_err  out  1  parity mismatch; qualified by rx_valid; 0 when PARITY_EN=0
- overrun_err  out  1  one-clk pulse: completed frame dropped
- busy  out  1  high in every state except IDLE

## Operation
- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun_err=0, busy=0. FSM=IDLE, tick_cnt=0, bit_cnt=0.
- tick_cnt is 4 bits and counts tick_16x only; bit_cnt is 3 bits; the shift register is DATA_BITS wide.
- IDLE: falling_edge=1 -> START, tick_cnt=0. Other inputs are ignored.
- START: on each tick, tick_cnt++. On the tick where tick_cnt==7 (start mid-bit), sample rx_filtered.
  - 0 -> DATA, tick_cnt=0, bit_cnt=0.
  - 1 -> IDLE. This is a false start: no flag, no output.
- DATA: on each tick, tick_cnt++. On the tick where tick_cnt==15, wrapping to 0, shift rx_filtered in at the MSB end (right shift, so the first bit lands in LSB) and bit_cnt++.
  - After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
- PARITY: sample at tick_cnt==15. parity_err_next = ^{data, sampled} XOR PARITY_ODD, so even parity gives 0 when correct. Then -> STOP.
- STOP: sample at tick_cnt==15. Any low stop sample sets frame_err_next. When STOP_BITS=2, a second 16-tick period is sampled the same way.
- Completion happens on the tick that samples the last stop bit. The FSM returns to IDLE, and the character is delivered as follows:
  - rx_valid=0, or rx_ready=1 in that cycle: load rx_data and the error flags, set rx_valid=1.
  - rx_valid=1 and rx_ready=0: keep the old contents and pulse overrun_err for one clk; the new frame is discarded.
- Handshake: rx_valid falls the clk after rx_valid && rx_ready, unless a load occurs in the same cycle; in that case rx_valid stays 1 with the new data. Contents are stable while rx_valid && !rx_ready.
- A frame error still delivers the character. A line held low (break) does not retrigger, because falling_edge needs a high-to-low transition.
- Reset asserted mid-frame clears everything immediately to the reset values. The partial frame is lost and no flag is raised.
- falling_edge is ignored in every state other than IDLE.

## Timing
- All state and outputs are registered; no combinational path from inputs to outputs.
- START decision: 8 ticks after the falling_edge strobe; the filter contributes its own latency upstream.
- Bit n sample: 8 + 16*(n+1) ticks after falling_edge; first data bit = 24 ticks.
- rx_valid rises 1 clk after the clk carrying the last-stop-sample tick. 8N1 frame: 8 + 16*9 = 152 ticks after falling_edge.
- overrun_err is coincident with the clk on which rx_valid would have loaded.
- busy falls in the same clk that rx_valid rises, or on a false-start return to IDLE.

## Structure
- Package uart_rx_pkg holds:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, PARITY, STOP}
  - localparams OSR=16, START_MID=7, BIT_END=15
- No sub-module; a single FSM-plus-datapath module.
- The uart_rx top instantiates the input filter and uart_rx_ctrl side by side, sharing clk, rst_n and tick_16x.

## Test plan
- 8N1, tick every 4 clk, send 0xA5 with rx_ready=1 -> rx_data=0xA5, rx_valid for 1 clk, frame_err=0, parity_err=0, 152 ticks after the edge.
- Glitch: line low for 3 ticks, then high -> START aborts at tick 7, FSM returns to IDLE, rx_valid never rises, busy pulses.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 1 -> parity_err=0; same frame with parity bit 0 -> parity_err=1, data 0x07.
- STOP_BITS=2: send 0x3C with the second stop bit low -> rx_data=0x3C, frame_err=1.
- rx_ready=0: send 0x11 then 0x22 -> rx_data stays 0x11, one-clk overrun_err at the second completion; rx_ready=1 in the exact completion clk instead -> rx_data=0x22, rx_valid stays 1, no overrun.
- Assert rst_n=0 during bit 4 of 0x55 -> all outputs 0 immediately; next clean frame 0x99 is received correctly.
